// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: harness/ROM-side bundle for the fetch controller.
// master = harness + ROM side, slave = fetch_ctrl.
interface fetch_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             start;
   logic [1:0]       task_sel;
   logic [19:0]      inst;
   logic             cmp_en;
   logic             flag_eq;
   logic             flag_lt;
   logic             flag_gt;
   logic [8:0]       iptr;
   logic             running;
   logic             done;
   logic [CNT_W-1:0] cycle_cnt;

   modport master (
      output start, task_sel, inst,
      output cmp_en, flag_eq, flag_lt, flag_gt,
      input  iptr, running, done, cycle_cnt
   );

   modport slave (
      input  start, task_sel, inst,
      input  cmp_en, flag_eq, flag_lt, flag_gt,
      output iptr, running, done, cycle_cnt
   );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC / fetch controller with PC-relative branches,
// a registered compare-flag set and a saturating cycle counter.
module fetch_ctrl #(
   parameter logic [8:0] START0 = 9'd1,
   parameter logic [8:0] START1 = 9'd25,
   parameter logic [8:0] START2 = 9'd42,
   parameter int         CNT_W  = 16
) (
   input  logic       Clk,
   input  logic       Reset,
   fetch_ctrl_if.slave bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [4:0] OP_BE   = 5'b00111;
   localparam logic [4:0] OP_BL   = 5'b01000;
   localparam logic [4:0] OP_BG   = 5'b01001;
   localparam logic [4:0] OP_BA   = 5'b01010;
   localparam logic [4:0] OP_DONE = 5'b01110;

   logic [1:0]       st_q, st_d;
   logic [8:0]       iptr_q, iptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       flg_q, flg_d;
   logic [4:0]       op;
   logic             taken;
   logic [8:0]       entry;

   assign op = bus.inst[19:15];

   // Branch resolution against the registered {eq,lt,gt} flags
   always_comb begin
      taken = 1'b0;
      case (op)
         OP_BE:   taken = flg_q[2];
         OP_BL:   taken = flg_q[1];
         OP_BG:   taken = flg_q[0];
         OP_BA:   taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

   // Entry address selected by task_sel
   always_comb begin
      entry = 9'd0;
      case (bus.task_sel)
         2'd0:    entry = START0;
         2'd1:    entry = START1;
         2'd2:    entry = START2;
         default: entry = 9'd0;
      endcase
   end

   // Next-state: launch from IDLE/DONE, step or branch in RUN
   always_comb begin
      st_d   = st_q;
      iptr_d = iptr_q;
      cnt_d  = cnt_q;
      flg_d  = flg_q;
      case (st_q)
         S_RUN: begin
            if (op == OP_DONE) begin
               st_d = S_DONE;
            end else if (taken) begin
               // Mod-512 add: only the low 9 offset bits matter
               iptr_d = 9'(iptr_q + bus.inst[14:0]);
            end else begin
               iptr_d = iptr_q + 9'd1;
            end
            if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
            if (bus.cmp_en) begin
               flg_d = {bus.flag_eq, bus.flag_lt, bus.flag_gt};
            end
         end
         default: begin
            if (bus.start) begin
               st_d   = S_RUN;
               iptr_d = entry;
               cnt_d  = '0;
               flg_d  = 3'b000;
            end
         end
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge Clk) begin
      if (Reset) begin
         st_q   <= S_IDLE;
         iptr_q <= 9'd0;
         cnt_q  <= '0;
         flg_q  <= 3'b000;
      end else begin
         st_q   <= st_d;
         iptr_q <= iptr_d;
         cnt_q  <= cnt_d;
         flg_q  <= flg_d;
      end
   end

   assign bus.iptr      = iptr_q;
   assign bus.running   = (st_q == S_RUN);
   assign bus.done      = (st_q == S_DONE);
   assign bus.cycle_cnt = cnt_q;
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Program-counter and fetch controller that drives the 9-bit instruction pointer into the instruction ROM and consumes the 20-bit instruction that comes back combinationally. It launches one of three program tasks on a start pulse and steps the pointer sequentially. It resolves the ROM's conditional and unconditional PC-relative branches against a compare-flag register, stops on the `done` opcode, and counts execution cycles for benchmarking. It sits between the top-level test harness (start/done handshake) and the instruction ROM / decode path.

## Interface
- `START0`, default 9'd1, entry address for task 0 (product)
- `START1`, default 9'd25, entry address for task 1 (string match)
- `START2`, default 9'd42, entry address for task 2 (closest pair)
- `CNT_W`, default 16, width of the cycle counter
- `Clk`  in  1  the only clock; all state updates on its rising edge
- `Reset`  in  1  synchronous, active-high reset
- `start`  in  1  single-cycle pulse that launches a task; sampled only in IDLE or DONE
- `task_sel`  in  2  task select, sampled with `start`: 0/1/2 select START0/1/2, 3 selects address 0
- `inst`  in  20  instruction returned by the ROM for the current `iptr`; fields are opcode [19:15] and offset [14:0]
- `cmp_en`  in  1  the ALU executed a compare this cycle; latch the flag inputs
- `flag_eq`, `flag_lt`, `flag_gt`  in  1 each  compare result from the ALU
- `iptr`  out  9  instruction pointer to the ROM (registered)
- `running`  out  1  high in RUN
- `done`  out  1  high in DONE, held until the next `start` or `Reset`
- `cycle_cnt`  out  CNT_W  count of RUN cycles for the current or last task

## Operation
- States: IDLE, RUN, DONE (3-state FSM). Reset state is IDLE.
- Reset values: `iptr`=0, `running`=0, `done`=0, `cycle_cnt`=0, flag register = 000.
- IDLE/DONE with `start`=1:
  - `iptr` <= entry address per `task_sel`.
  - `cycle_cnt` <= 0 and flags <= 000.
  - State goes to RUN.
- IDLE/DONE without `start`: all registers hold.
- RUN, on each edge, decode `inst[19:15]`:
  - 01110 `done`: go to DONE. `iptr` holds, pointing at the done instruction.
  - 00111 `be`: taken if eq_flag.
  - 01000 `bl`: taken if lt_flag.
  - 01001 `bg`: taken if gt_flag.
  - 01010 `ba`: always taken.
  - Any other opcode: not a branch.
- Next pointer when a branch is taken: `iptr` <= (`iptr` + sign-extended `inst[14:0]`) mod 512. Only the low 9 bits are kept; the offset is relative to the branch's own address.
- Next pointer otherwise: `iptr` <= `iptr`+1 mod 512, so 511 wraps to 0.
- Flag register:
  - When `cmp_en`=1 in RUN, load {eq,lt,gt} at the edge.
  - Branches always use the registered flags, i.e. the most recent earlier compare.
  - A compare and a branch in the same cycle is impossible, since execution is one instruction per cycle. If it occurs anyway, the branch uses the old flags and the new flags are latched.
- `cycle_cnt` increments at every edge that ends a RUN cycle, including the cycle that fetches `done`. It saturates at all-ones.
- `start` during RUN is ignored.

## Timing
- `iptr` and all outputs are registered; no combinational path from inputs to outputs.
- Launch: `start` sampled at edge N. At N: `iptr`=entry, `running`=1, `done`=0. `inst` is valid combinationally during cycle N..N+1.
- Each instruction takes one cycle. The branch decision and next `iptr` are available at the following edge (zero bubble).
- Completion: if `done` is fetched in the cycle ending at edge M, then at M `running`=0 and `done`=1.
- `Reset` mid-RUN returns all outputs to reset values at the next edge, regardless of `start`. `Reset` wins over a simultaneous `start`.
- Entry address for `task_sel`=3 is 0. The `done` instruction there finishes after 1 cycle with `cycle_cnt`=1.

## Test plan
- Reset: hold `Reset` 2 cycles with `start`=1 -> `iptr`=0, `running`=0, `done`=0, `cycle_cnt`=0.
- Launch/sequential: `start`, `task_sel`=0 -> next edge `iptr`=1, `running`=1. Non-branch ROM contents step 1,2,3,4 on successive edges.
- Conditional branch:
  - `cmp_en` with eq=1 at iptr 4, then inst=`00111_000000000000100` at iptr 5 -> `iptr`=9.
  - Same with eq=0 -> `iptr`=6.
- Backward branch/wrap:
  - lt flag set, inst=`01000_111111111110011` at iptr 0x10 -> `iptr`=3.
  - `ba` with offset +1 at iptr 511 -> `iptr`=0.
- Done/counter: `task_sel`=3 -> `done`=1 after 1 RUN cycle, `cycle_cnt`=1. `done` is held; a fresh `start` clears it and reloads the entry.
- Mid-run reset: assert `Reset` at RUN cycle 7 -> next edge IDLE with all outputs at reset values. A later `start` runs normally with flags cleared.
